// File: rtl/alu_operand_issue.sv
// Operand-issue and result-capture stage around a combinational ALU.
// Queues operand pairs in a small FIFO, drives the head onto the ALU and registers its result.
module alu_operand_issue #(
  parameter int OPERAND_WIDTH = 4,
  parameter int RESULT_WIDTH  = 6,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*OPERAND_WIDTH-1:0] in_vector,
  output logic [OPERAND_WIDTH-1:0]   alu_a,
  output logic [OPERAND_WIDTH-1:0]   alu_b,
  input  logic [RESULT_WIDTH-1:0]    alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RESULT_WIDTH-1:0]    out_vector,
  output logic [15:0]                op_count
);

  localparam int PAIR_W = 2 * OPERAND_WIDTH;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  logic [PAIR_W-1:0]       mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [CNT_W-1:0]        count_reg;
  logic                    out_valid_reg;
  logic [RESULT_WIDTH-1:0] out_vector_reg;
  logic [15:0]             op_count_reg;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              slot_free;
  logic [PAIR_W-1:0] head;

  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  // Readiness depends only on FIFO occupancy, so a pop in the same cycle never opens a full FIFO.
  assign in_ready   = !rst && !fifo_full;
  assign push       = in_valid && in_ready;
  assign slot_free  = !out_valid_reg || out_ready;
  assign pop        = !fifo_empty && slot_free;

  assign head  = mem_reg[rd_ptr_reg];
  assign alu_a = fifo_empty ? '0 : head[PAIR_W-1:OPERAND_WIDTH];
  assign alu_b = fifo_empty ? '0 : head[OPERAND_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= in_vector;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A fresh capture takes priority over draining the slot; out_vector keeps its value when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_vector_reg <= '0;
    end else if (pop) begin
      out_valid_reg  <= 1'b1;
      out_vector_reg <= alu_result;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_reg <= '0;
    end else if (out_valid_reg && out_ready) begin
      op_count_reg <= op_count_reg + 16'd1;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_vector = out_vector_reg;
  assign op_count   = op_count_reg;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue with a behavioural adder on the ALU port.
// Accepted pairs queue their sum; a monitor pops and compares on each output handshake.
module tb_alu_operand_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vector;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [5:0] alu_result;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_vector;
  logic [15:0] op_count;

  int checks   = 0;
  int failures = 0;

  int          exp_q[$];
  logic [15:0] exp_count = 16'd0;
  bit          started   = 1'b0;

  always #5 clk = ~clk;

  assign alu_result = 6'(alu_a) + 6'(alu_b);

  alu_operand_issue #(
    .OPERAND_WIDTH(4),
    .RESULT_WIDTH (6),
    .FIFO_DEPTH   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vector (in_vector),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_result(alu_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vector(out_vector),
    .op_count  (op_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pair_sum(input logic [7:0] v);
    return int'(v[7:4]) + int'(v[3:0]);
  endfunction

  // Monitor: inputs are stable from posedge+1 to the next posedge, so the handshakes seen here
  // are exactly those taken at the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_count = 16'd0;
      started   = 1'b1;
    end else if (started) begin
      chk("op_count_track", 32'(op_count), 32'(exp_count));
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL result_extra: got %0d with no result outstanding at %0t", out_vector, $time);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (32'(out_vector) !== 32'(e)) begin
            failures++;
            $display("FAIL result_order: got %0d expected %0d at %0t", out_vector, e, $time);
          end
        end
        exp_count = exp_count + 16'd1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(pair_sum(in_vector));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    bit acc;
    acc       = 1'b0;
    in_valid  = 1'b1;
    in_vector = v;
    for (int t = 0; t < 50 && !acc; t++) begin
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 50 && (exp_q.size() != 0 || out_valid); t++) begin
      step();
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vector = 8'h00;
    out_ready = 1'b0;

    // 1. reset
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_vector", 32'(out_vector), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    rst = 1'b0;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("empty_alu_a", 32'(alu_a), 32'd0);
    chk("empty_alu_b", 32'(alu_b), 32'd0);

    // 2. single pair, latency
    out_ready = 1'b1;
    push(8'h35);
    chk("head_alu_a", 32'(alu_a), 32'd3);
    chk("head_alu_b", 32'(alu_b), 32'd5);
    chk("no_bypass", 32'(out_valid), 32'd0);
    step();
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_out_vector", 32'(out_vector), 32'd8);
    step();
    chk("first_op_count", 32'(op_count), 32'd1);
    chk("drained_out_valid", 32'(out_valid), 32'd0);
    chk("drained_out_vector_hold", 32'(out_vector), 32'd8);

    // 3. backpressure and capacity
    out_ready = 1'b0;
    push(8'hFF);
    push(8'h12);
    push(8'h21);
    in_valid  = 1'b1;
    in_vector = 8'h44;
    for (int i = 0; i < 3; i++) begin
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_vector", 32'(out_vector), 32'd30);
      step();
    end
    out_ready = 1'b1;
    push(8'h44);
    drain();

    // 4. back-to-back streaming with no bubbles
    base      = exp_count;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_vector = 8'($urandom);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      if (i >= 1) chk("stream_no_bubble", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_last_valid", 32'(out_valid), 32'd1);
    step();
    chk("stream_done_valid", 32'(out_valid), 32'd0);
    chk("stream_op_count", 32'(op_count), 32'(base + 16'd8));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_vector = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    drain();

    // 5. reset with two pairs queued and a result held
    out_ready = 1'b0;
    push(8'($urandom));
    push(8'($urandom));
    push(8'($urandom));
    chk("prereset_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_high_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_vector", 32'(out_vector), 32'd0);
    chk("midrst_op_count", 32'(op_count), 32'd0);
    chk("midrst_alu_a", 32'(alu_a), 32'd0);
    chk("midrst_alu_b", 32'(alu_b), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_stale_result", 32'(out_valid), 32'd0);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    end

    // 6. op_count wrap
    in_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      in_vector = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("wrap_op_count", 32'(op_count), 32'd0);
    push(8'h11);
    step();
    step();
    chk("post_wrap_op_count", 32'(op_count), 32'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
